// File: rtl/fetch_unit.sv
// Instruction fetch unit: IDLE/REQ/DRAIN cache requester feeding a 2-entry {pc, instr} buffer.
// Optional stall counter is built only when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  output logic        read,
  output logic [31:0] addr,
  input  logic        ready,
  input  logic [31:0] load,
  output logic        done,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] stall_cycles
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 2;

  typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] word;
  } fetch_entry_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] addr_inc;
  fetch_entry_t    fifo_q [DEPTH];
  logic            head_q;
  logic            tail;
  logic [1:0]      count_q;
  logic [1:0]      count_post;
  logic            push;
  logic            pop;
  logic            start;
  logic            advance;

  assign read        = (state_q != IDLE);
  assign done        = read & ready;
  assign addr        = addr_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = fifo_q[head_q].word;
  assign instr_pc    = fifo_q[head_q].pc;

  // Redirect squashes both the returning word and any decode pop in that cycle.
  assign push       = (state_q == REQ) & ready & ~redirect;
  assign pop        = instr_valid & instr_ready & ~redirect;
  assign tail       = head_q ^ count_q[0];
  assign addr_inc   = addr_q + XLEN'(4);
  assign count_post = count_q + 2'd1 - 2'(pop);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (!halt && count_q < 2'(DEPTH) && !redirect) begin
          state_d = REQ;
          start   = 1'b1;
        end
      end
      REQ: begin
        if (ready) begin
          if (!redirect && !halt && count_post < 2'(DEPTH)) begin
            state_d = REQ;
            advance = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Fetch pointer, request address and buffer occupancy
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      count_q <= 2'd0;
      head_q  <= 1'b0;
    end else begin
      if (redirect)  pc_q <= redirect_pc;
      else if (push) pc_q <= addr_inc;

      if (start)        addr_q <= pc_q;
      else if (advance) addr_q <= addr_inc;

      if (redirect) count_q <= 2'd0;
      else          count_q <= count_q + 2'(push) - 2'(pop);

      if (pop) head_q <= ~head_q;
    end
  end

  // Buffer storage needs no reset; occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) fifo_q[tail] <= '{pc: addr_q, word: load};
  end

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] stall_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)                                   stall_q <= '0;
    else if (redirect)                           stall_q <= '0;
    else if (read && !ready && stall_q != '1)    stall_q <= stall_q + XLEN'(1);
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, back-pressure, redirects, halt, reset and PC wrap.
module tb_fetch_unit;

  logic        clk;
  logic        nrst;
  logic        read, done, instr_valid;
  logic [31:0] addr, instr, instr_pc, stall_cycles;
  logic        ready, redirect, halt, instr_ready;
  logic [31:0] load, redirect_pc;

  logic        read2, done2, instr_valid2;
  logic [31:0] addr2, instr2, instr_pc2, stall2;
  logic        ready2;
  logic [31:0] load2;

  int vectors;
  int miscompares;
  logic [31:0] stall_exp;

  fetch_unit dut (
    .clk(clk), .nrst(nrst), .read(read), .addr(addr), .ready(ready), .load(load),
    .done(done), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .instr_pc(instr_pc), .stall_cycles(stall_cycles)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .nrst(nrst), .read(read2), .addr(addr2), .ready(ready2), .load(load2),
    .done(done2), .redirect(1'b0), .redirect_pc(32'd0), .halt(1'b0),
    .instr_valid(instr_valid2), .instr_ready(1'b1), .instr(instr2),
    .instr_pc(instr_pc2), .stall_cycles(stall2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word(input int i);
    return 32'hA500_0000 + 32'(i);
  endfunction

  initial begin
    vectors = 0; miscompares = 0;
    nrst = 1'b0; ready = 1'b1; load = 32'd0; redirect = 1'b0; redirect_pc = 32'd0;
    halt = 1'b0; instr_ready = 1'b0; ready2 = 1'b0; load2 = 32'h1234_5678;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", 32'(read), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_stall", stall_cycles, 32'd0);
    chk("rst_read2", 32'(read2), 32'd0);
    ready = 1'b0;
    nrst = 1'b1;
    #1 chk("idle_after_rst", 32'(read), 32'd0);

    // First request, then buffer fills with decode stalled
    tick();
    chk("first_read", 32'(read), 32'd1);
    chk("first_addr", addr, 32'h0);
    chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    tick();
    ready = 1'b1; load = word(0); ready2 = 1'b1;
    #1 chk("done_hit0", 32'(done), 32'd1);
    tick();
    ready = 1'b0; ready2 = 1'b0;
    chk("addr_after0", addr, 32'h4);
    chk("valid0", 32'(instr_valid), 32'd1);
    chk("pc0", instr_pc, 32'h0);
    chk("instr0", instr, word(0));
    chk("wrap_second_addr", addr2, 32'h0);
    chk("wrap_pc", instr_pc2, 32'hFFFF_FFFC);
    tick();
    ready = 1'b1; load = word(1);
    tick();
    ready = 1'b0;
    chk("full_read", 32'(read), 32'd0);
    chk("full_head", instr_pc, 32'h0);
    tick(); tick();
    chk("full_read_hold", 32'(read), 32'd0);
    chk("full_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("pop_head", instr_pc, 32'h4);
    chk("pop_read", 32'(read), 32'd0);
    tick();
    chk("refetch_read", 32'(read), 32'd1);
    chk("refetch_addr", addr, 32'h8);

    // Streaming hits at one instruction per two cycles
    instr_ready = 1'b1;
    for (int i = 2; i < 16; i++) begin
      chk("stream_addr", addr, 32'(4 * i));
      chk("stream_read", 32'(read), 32'd1);
      tick();
      ready = 1'b1; load = word(i);
      #1 chk("stream_done", 32'(done), 32'd1);
      tick();
      ready = 1'b0;
      chk("stream_valid", 32'(instr_valid), 32'd1);
      chk("stream_pc", instr_pc, 32'(4 * i));
      chk("stream_instr", instr, word(i));
    end

    // Redirect while a miss at 0x40 is outstanding
    chk("miss_addr", addr, 32'h40);
    redirect = 1'b1; redirect_pc = 32'h100;
    #1 chk("miss_done0", 32'(done), 32'd0);
    tick();
    redirect = 1'b0;
    chk("drain_addr", addr, 32'h40);
    chk("drain_read", 32'(read), 32'd1);
    chk("drain_flush", 32'(instr_valid), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("drain_wait_addr", addr, 32'h40);
      chk("drain_wait_read", 32'(read), 32'd1);
    end
    tick();
    ready = 1'b1; load = 32'hDEAD_BEEF;
    #1 chk("drain_done", 32'(done), 32'd1);
    tick();
    ready = 1'b0;
    chk("drain_idle", 32'(read), 32'd0);
    chk("drain_dropped", 32'(instr_valid), 32'd0);
    tick();
    chk("redir_addr", addr, 32'h100);
    chk("redir_read", 32'(read), 32'd1);
    chk("redir_novalid", 32'(instr_valid), 32'd0);
    tick();
    ready = 1'b1; load = word(64);
    tick();
    ready = 1'b0;
    chk("redir_pc", instr_pc, 32'h100);
    chk("redir_next", addr, 32'h104);

    // Redirect coincident with ready, flushing a buffered entry
    instr_ready = 1'b0;
    tick();
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h20; load = 32'hBAD0_0001;
    #1 chk("samecyc_done", 32'(done), 32'd1);
    chk("samecyc_valid", 32'(instr_valid), 32'd1);
    tick();
    ready = 1'b0; redirect = 1'b0; instr_ready = 1'b1;
    chk("samecyc_flush", 32'(instr_valid), 32'd0);
    chk("samecyc_idle", 32'(read), 32'd0);
    tick();
    chk("samecyc_addr", addr, 32'h20);
    tick();
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200; load = 32'hBAD0_0002;
    #1 chk("r20_done", 32'(done), 32'd1);
    tick();
    ready = 1'b0; redirect = 1'b0;
    chk("r20_flush", 32'(instr_valid), 32'd0);
    chk("r20_idle", 32'(read), 32'd0);
    tick();
    chk("r20_addr", addr, 32'h200);
    chk("r20_read", 32'(read), 32'd1);

    // Halt lets the outstanding request finish but blocks new starts
    halt = 1'b1;
    tick();
    ready = 1'b1; load = word(128);
    tick();
    ready = 1'b0;
    chk("halt_push_valid", 32'(instr_valid), 32'd1);
    chk("halt_push_pc", instr_pc, 32'h200);
    chk("halt_push_instr", instr, word(128));
    chk("halt_idle", 32'(read), 32'd0);
    tick(); tick();
    chk("halt_hold", 32'(read), 32'd0);
    halt = 1'b0;
    tick();
    chk("unhalt_addr", addr, 32'h204);
    chk("unhalt_read", 32'(read), 32'd1);

    // Reset mid-transaction, then a 7-cycle miss
    nrst = 1'b0;
    #1;
    chk("midrst_read", 32'(read), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_stall", stall_cycles, 32'd0);
    nrst = 1'b1;
    tick();
    chk("postrst_addr", addr, 32'h0);
    chk("postrst_read", 32'(read), 32'd1);
    repeat (7) tick();
`ifdef FETCH_PERF_CNT_EN
    stall_exp = 32'd7;
`else
    stall_exp = 32'd0;
`endif
    ready = 1'b1; load = word(7);
    #1 chk("miss7_done", 32'(done), 32'd1);
    chk("miss7_stall", stall_cycles, stall_exp);
    tick();
    ready = 1'b0;
    chk("miss7_stall_hold", stall_cycles, stall_exp);
    chk("miss7_pc", instr_pc, 32'h0);
    chk("miss7_instr", instr, word(7));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port nrst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The block SHALL have port read, output, 1 bit: instruction cache read request.
REQ-005 The block SHALL have port addr, output, 32 bits: cache request address.
REQ-006 The block SHALL have port ready, input, 1 bit: cache data valid on load.
REQ-007 The block SHALL have port load, input, 32 bits: cache read data.
REQ-008 The block SHALL have port done, output, 1 bit: accept/complete the cache transaction.
REQ-009 The block SHALL have port redirect, input, 1 bit: branch/jump redirect pulse.
REQ-010 The block SHALL have port redirect_pc, input, 32 bits: redirect target, word aligned.
REQ-011 The block SHALL have port halt, input, 1 bit: suppress new fetch starts.
REQ-012 The block SHALL have port instr_valid, output, 1 bit: instruction available to decode.
REQ-013 The block SHALL have port instr_ready, input, 1 bit: decode accepts the instruction.
REQ-014 The block SHALL have port instr, output, 32 bits: instruction word at the buffer head.
REQ-015 The block SHALL have port instr_pc, output, 32 bits: address of instr.
REQ-016 The block SHALL have port stall_cycles, output, 32 bits: fetch stall counter (see Configuration).

Function
REQ-017 The block SHALL implement states IDLE, REQ and DRAIN; read SHALL be 1 exactly in REQ and DRAIN.
REQ-018 The block SHALL hold a 2-entry FIFO of {pc, instr}; instr_valid SHALL equal (count != 0); instr and instr_pc SHALL be the head entry.
REQ-019 In IDLE, the block SHALL move to REQ when !halt && count < 2 && !redirect, with addr = fetch pc.
REQ-020 In REQ, addr SHALL be held stable and read held at 1 until the cycle ready = 1.
REQ-021 done SHALL equal read && ready, combinationally; the block SHALL never drop read before done.
REQ-022 On done in REQ without redirect, the block SHALL push {addr, load}, and pc SHALL become addr + 4, wrapping 32'hFFFF_FFFC to 32'h0000_0000.
REQ-023 After a done in REQ, the block SHALL remain in REQ with the new addr if !halt and the post-update count < 2; otherwise it SHALL go to IDLE.
REQ-024 A push SHALL never find the FIFO full: a request is only started with a free slot, and only pops occur while it is outstanding.
REQ-025 A pop SHALL occur when instr_valid && instr_ready; a push and a pop in the same cycle SHALL leave count unchanged.
REQ-026 On redirect, the FIFO SHALL flush (count = 0 next cycle), any same-cycle pop or push SHALL be discarded, and pc SHALL load redirect_pc.
REQ-027 If redirect arrives in REQ with ready = 0, the block SHALL go to DRAIN, keep the old addr, and wait for ready.
REQ-028 In DRAIN, the block SHALL assert done on ready, discard load, and go to IDLE; a further redirect in DRAIN SHALL only update pc.
REQ-029 If redirect arrives in REQ with ready = 1, done SHALL assert, the data SHALL be discarded, and the next state SHALL be IDLE.
REQ-030 halt SHALL block only request starts; an outstanding request SHALL complete and push normally.
REQ-031 Steady-state hit throughput SHALL be one instruction every 2 cycles (cache IDLE/CHECK turnaround).

Reset
REQ-032 While nrst = 0, state SHALL be IDLE, count 0, pc RESET_PC, read 0, done 0, instr_valid 0, and stall_cycles 0.
REQ-033 Reset asserted mid-transaction SHALL abandon the transaction immediately, because the cache resets with the same nrst.
REQ-034 After reset releases, the first read SHALL assert in the second clock edge's cycle with addr = RESET_PC.

Configuration
REQ-035 With macro FETCH_PERF_CNT_EN defined, stall_cycles SHALL increment each cycle that read && !ready, saturate at 32'hFFFF_FFFF, and clear on redirect.
REQ-036 Without FETCH_PERF_CNT_EN, stall_cycles SHALL be constant 0 and no counter logic SHALL be generated.

Verification
REQ-037 Reset release, cache hits returning ready 1 cycle after read, instr_ready = 1 -> addr sequence 0x0, 0x4, 0x8, ..., with instr_pc matching each pushed word.
REQ-038 instr_ready = 0 -> exactly 2 entries buffered, read = 0 afterwards; one pop -> one new request at 0x8.
REQ-039 Redirect to 0x100 while REQ at 0x40 waits 5 cycles for ready -> addr stays 0x40, done on ready, data dropped, next read addr = 0x100, no 0x40 instruction visible.
REQ-040 Redirect in the same cycle as ready for 0x20 -> done = 1, FIFO empty next cycle, next addr = redirect_pc.
REQ-041 RESET_PC = 32'hFFFF_FFFC -> second fetch addr = 0x0.
REQ-042 With FETCH_PERF_CNT_EN defined, a miss with ready after 7 cycles -> stall_cycles = 7; without the macro, stall_cycles = 0.
